opamp_pp_meter: RTL

// - Digital measurement stage downstream of the op-amp bandpass macromodel output, after its ADC.
// - Consumes signed ADC samples of the filter output over fixed windows of 2^WIN_LOG2 samples.
// - Reports peak-to-peak amplitude and window mean per window over a valid/ready result channel.
// - Double-buffered: accumulation continues while a result waits for acceptance.

---
 rtl/opamp_meter_pkg.sv | 33 +++
 rtl/opamp_minmax_tracker.sv | 49 ++++
 rtl/opamp_pp_meter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/opamp_meter_pkg.sv
// -----------------------------------------------------------------------------
// opamp_meter_pkg : shared types, widths and clip rails for the pp/mean meter
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package opamp_meter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    ACCUM = 2'd2
  } state_e;

  function automatic int sum_width(input int dw, input int win_log2);
    return dw + win_log2;
  endfunction

  function automatic int pp_width(input int dw);
    return dw + 1;
  endfunction

  function automatic int clip_hi(input int dw, input int margin);
    return (2 ** (dw - 1)) - 1 - margin;
  endfunction

  function automatic int clip_lo(input int dw, input int margin);
    return -(2 ** (dw - 1)) + margin;
  endfunction

endpackage

`default_nettype wire

// File: rtl/opamp_minmax_tracker.sv
// -----------------------------------------------------------------------------
// opamp_minmax_tracker : running signed min/max over the current window
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module opamp_minmax_tracker #(
  parameter int DW = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 update,
  input  logic signed [DW-1:0] sample,
  output logic signed [DW-1:0] min,
  output logic signed [DW-1:0] max
);

  logic signed [DW-1:0] min_q, min_d;
  logic signed [DW-1:0] max_q, max_d;

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (load) begin
      min_d = sample;
      max_d = sample;
    end else if (update) begin
      if (sample < min_q) min_d = sample;
      if (sample > max_q) max_d = sample;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_q <= '0;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign min = min_q;
  assign max = max_q;

endmodule

`default_nettype wire

// File: rtl/opamp_pp_meter.sv
// -----------------------------------------------------------------------------
// opamp_pp_meter : per-window peak-to-peak and mean of signed ADC samples,
// double-buffered onto a valid/ready result channel. Optional CLIP_DETECT_EN.
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module opamp_pp_meter
  import opamp_meter_pkg::*;
#(
  parameter int DW          = 12,
  parameter int WIN_LOG2    = 8,
  parameter int CLIP_MARGIN = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 s_valid,
  input  logic signed [DW-1:0] s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DW:0]          m_pp,
  output logic signed [DW-1:0] m_mean,
  output logic                 overrun
`ifdef CLIP_DETECT_EN
  ,
  output logic                 clip
`endif
);

  localparam int SUM_W = sum_width(DW, WIN_LOG2);
  localparam int PP_W  = pp_width(DW);

  state_e                   state_q, state_d;
  logic [WIN_LOG2-1:0]      count_q, count_d;
  logic signed [SUM_W-1:0]  sum_q, sum_d;
  logic                     en_q;
  logic                     m_valid_q, m_valid_d;
  logic [PP_W-1:0]          m_pp_q, m_pp_d;
  logic signed [DW-1:0]     m_mean_q, m_mean_d;
  logic                     overrun_q, overrun_d;

  logic                     w_accept;
  logic                     w_in_window;
  logic                     w_complete;
  logic                     w_load_result;
  logic signed [SUM_W-1:0]  w_sample_ext;
  logic signed [SUM_W-1:0]  w_sum_upd;
  logic signed [DW-1:0]     w_trk_sample;
  logic signed [DW-1:0]     w_trk_min, w_trk_max;
  logic signed [DW-1:0]     w_fin_min, w_fin_max;
  logic [PP_W-1:0]          w_fin_pp;

  assign w_accept      = s_valid && en;
  assign w_in_window   = (state_q == ACCUM);
  assign w_complete    = w_accept && w_in_window && (count_q == '1);
  assign w_load_result = w_complete && (!m_valid_q || m_ready);
  assign w_sample_ext  = {{WIN_LOG2{s_data[DW-1]}}, s_data};
  assign w_sum_upd     = sum_q + w_sample_ext;
  assign w_trk_sample  = en ? s_data : '0;

  opamp_minmax_tracker #(.DW(DW)) u_tracker (
    .clk    (clk),
    .rst    (rst),
    .load   (!en || (w_accept && !w_in_window)),
    .update (w_accept && w_in_window),
    .sample (w_trk_sample),
    .min    (w_trk_min),
    .max    (w_trk_max)
  );

  // Result uses the extremes including the completing sample itself.
  assign w_fin_min = (s_data < w_trk_min) ? s_data : w_trk_min;
  assign w_fin_max = (s_data > w_trk_max) ? s_data : w_trk_max;
  assign w_fin_pp  = {w_fin_max[DW-1], w_fin_max} - {w_fin_min[DW-1], w_fin_min};

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    sum_d     = sum_q;
    m_valid_d = m_valid_q && !m_ready;
    m_pp_d    = m_pp_q;
    m_mean_d  = m_mean_q;
    overrun_d = overrun_q;

    if (!en) begin
      state_d = IDLE;
      count_d = '0;
      sum_d   = '0;
    end else if (w_accept) begin
      if (!w_in_window) begin
        state_d = ACCUM;
        count_d = {{(WIN_LOG2-1){1'b0}}, 1'b1};
        sum_d   = w_sample_ext;
      end else if (w_complete) begin
        state_d = FIRST;
        count_d = '0;
        sum_d   = '0;
      end else begin
        count_d = count_q + 1'b1;
        sum_d   = w_sum_upd;
      end
    end else if (state_q == IDLE) begin
      state_d = FIRST;
    end

    // Top DW bits of the full-width sum are the floor division by the window length.
    if (w_load_result) begin
      m_valid_d = 1'b1;
      m_pp_d    = w_fin_pp;
      m_mean_d  = w_sum_upd[SUM_W-1:WIN_LOG2];
    end else if (w_complete) begin
      overrun_d = 1'b1;
    end

    if (en_q && !en) overrun_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      sum_q     <= '0;
      en_q      <= 1'b0;
      m_valid_q <= 1'b0;
      m_pp_q    <= '0;
      m_mean_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      sum_q     <= sum_d;
      en_q      <= en;
      m_valid_q <= m_valid_d;
      m_pp_q    <= m_pp_d;
      m_mean_q  <= m_mean_d;
      overrun_q <= overrun_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_pp    = m_pp_q;
  assign m_mean  = m_mean_q;
  assign overrun = overrun_q;

`ifdef CLIP_DETECT_EN
  localparam logic signed [DW-1:0] CLIP_HI = DW'(clip_hi(DW, CLIP_MARGIN));
  localparam logic signed [DW-1:0] CLIP_LO = DW'(clip_lo(DW, CLIP_MARGIN));

  logic clip_acc_q, clip_acc_d;
  logic clip_q, clip_d;
  logic w_samp_clip;

  assign w_samp_clip = (s_data >= CLIP_HI) || (s_data <= CLIP_LO);

  always_comb begin
    clip_acc_d = clip_acc_q;
    clip_d     = clip_q;
    if (!en) begin
      clip_acc_d = 1'b0;
    end else if (w_accept) begin
      if (!w_in_window)    clip_acc_d = w_samp_clip;
      else if (w_complete) clip_acc_d = 1'b0;
      else                 clip_acc_d = clip_acc_q || w_samp_clip;
    end
    if (w_load_result) clip_d = clip_acc_q || w_samp_clip;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clip_acc_q <= 1'b0;
      clip_q     <= 1'b0;
    end else begin
      clip_acc_q <= clip_acc_d;
      clip_q     <= clip_d;
    end
  end

  assign clip = clip_q;
`endif

endmodule

`default_nettype wire
